// File: rtl/key_evt_pkg.sv
// Shared types and helpers for the key event controller and its FIFO path.
// KEY_EVENT_CTRL_TIMESTAMP_EN adds a timestamp field to each event.
package key_evt_pkg;

  localparam int TS_W     = 16;
  localparam int CH_MAX_W = 7;

  function automatic int ch_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  typedef struct packed {
    logic [CH_MAX_W-1:0] ch;
    logic                rise;
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
    logic [TS_W-1:0]     ts;
`endif
  } evt_t;

endpackage

// File: rtl/key_event_ctrl_if.sv
// Event stream towards the FT2232H FIFO writer (valid/ready handshake).
// KEY_EVENT_CTRL_TIMESTAMP_EN adds the evt_ts field.
interface key_event_ctrl_if #(parameter int CH_W = 3);
  import key_evt_pkg::*;

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_rise;
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
  logic [TS_W-1:0] evt_ts;

  modport master (output evt_valid, output evt_ch, output evt_rise, output evt_ts, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_rise, input evt_ts, output evt_ready);
`else
  modport master (output evt_valid, output evt_ch, output evt_rise, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_rise, output evt_ready);
`endif
endinterface

// File: rtl/evt_fifo.sv
// Synchronous FIFO with registered head data and flags; head reads zero while empty.
module evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             push_s, pop_s;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_s    = !empty_q && rd_en;
    // A full queue still accepts a write when the head leaves in the same cycle.
    push_s   = wr_en && (!full_q || pop_s);
    if (push_s) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == (AW+1)'(DEPTH));
    if (empty_d) begin
      data_d = '0;
    end else begin
      data_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = data_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Round-robin debouncer: one shared counter datapath visits one channel per clock
// and queues press/release events. KEY_EVENT_CTRL_TIMESTAMP_EN adds evt_ts.
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 65535,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] stable_out,
  key_event_ctrl_if.master  evt_if,
  output logic              ovf,
  input  logic              clr_ovf
);
  localparam int CH_W = ch_width(NUM_CH);
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
  localparam int TS_BITS = TS_W;
`else
  localparam int TS_BITS = 0;
`endif
  localparam int FW = CH_W + 1 + TS_BITS;
  localparam logic [CNT_W-1:0] STABLE_VAL = CNT_W'(STABLE_CNT);

  logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_CH-1:0] last_q, last_d, stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CH_W-1:0]   idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic              push_s, pop_s, drop_s;
  evt_t              push_evt_s;
  logic [FW-1:0]     fifo_wdata_s, fifo_rdata_s;
  logic              fifo_full_s, fifo_empty_s;
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_q, ts_d;
`endif

  always_comb begin
    sync1_d    = raw_in;
    sync2_d    = sync1_q;
    last_d     = last_q;
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    push_s     = 1'b0;
    push_evt_s = '0;
    if (idx_q == CH_W'(NUM_CH - 1)) begin
      idx_d = '0;
    end else begin
      idx_d = idx_q + 1'b1;
    end
    if (sync2_q[idx_q] != last_q[idx_q]) begin
      last_d[idx_q] = sync2_q[idx_q];
      cnt_d[idx_q]  = '0;
    end else if (cnt_q[idx_q] < STABLE_VAL) begin
      cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
    end else if (stable_q[idx_q] != last_q[idx_q]) begin
      stable_d[idx_q]  = last_q[idx_q];
      push_s           = 1'b1;
      push_evt_s.ch    = CH_MAX_W'(idx_q);
      push_evt_s.rise  = last_q[idx_q];
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
      push_evt_s.ts    = ts_q;
`endif
    end else begin
      push_s = 1'b0;
    end
    // A drop still updates stable_out; only the queue entry is lost.
    drop_s = push_s && fifo_full_s && !pop_s;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      last_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '{default: '0};
      idx_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      last_q   <= last_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
  assign ts_d = ts_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign fifo_wdata_s  = {CH_W'(push_evt_s.ch), push_evt_s.rise, push_evt_s.ts};
  assign evt_if.evt_ts = fifo_rdata_s[TS_W-1:0];
`else
  assign fifo_wdata_s  = {CH_W'(push_evt_s.ch), push_evt_s.rise};
`endif

  assign pop_s = evt_if.evt_valid && evt_if.evt_ready;

  evt_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_s),
    .wr_data (fifo_wdata_s),
    .rd_en   (evt_if.evt_ready),
    .rd_data (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign evt_if.evt_valid = !fifo_empty_s;
  assign evt_if.evt_ch    = fifo_rdata_s[FW-1 -: CH_W];
  assign evt_if.evt_rise  = fifo_rdata_s[TS_BITS];
  assign stable_out       = stable_q;
  assign ovf              = ovf_q;

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Time-shared debounce controller for NUM_CH raw inputs (push-buttons, strap/config switches).
- One shared stability-counter datapath is scheduled round-robin across channels, one channel per clock.
- Press/release events go into a small queue drained by the FT2232H FIFO write path over a valid/ready handshake.

Parameters:
- NUM_CH, 8, number of raw input channels (2..128).
- CNT_W, 16, stability counter width.
- STABLE_CNT, 65535, required consecutive equal samples on a channel, < 2^CNT_W.
- FIFO_DEPTH, 8, event queue depth, power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- raw_in  in  NUM_CH  asynchronous raw inputs.
- stable_out  out  NUM_CH  debounced levels.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_ch  out  CH_W  channel index of event, CH_W = max(1, clog2(NUM_CH)).
- evt_rise  out  1  1 = 0→1 transition, 0 = 1→0 transition.
- ovf  out  1  sticky: an event was dropped.
- clr_ovf  in  1  clears ovf.

Behaviour:
- Single clock domain. Reset is synchronous, active-low, sampled on clk rising edge.
- Reset (rst_n=0 at an edge) clears all state: sync regs, last_sample, cnt[], stable_out=0, scan idx=0, FIFO empty (evt_valid=0), ovf=0. evt_ch and evt_rise read 0 while the FIFO is empty after reset.
- Reset mid-operation flushes queued events; evt_valid=0 from the first edge with rst_n=0.
- Input sync: 2-FF synchronizer per channel, giving sync_in.
- Scan: idx advances by 1 every cycle, NUM_CH-1 wraps to 0. Only channel idx is updated in a cycle.
- Per visit of channel c:
  - If sync_in[c] != last_sample[c]: last_sample[c] <= sync_in[c], cnt[c] <= 0.
  - Else if cnt[c] < STABLE_CNT: cnt[c] <= cnt[c]+1.
  - Else if stable_out[c] != last_sample[c]: stable_out[c] <= last_sample[c], and an event {c, last_sample[c]} is pushed.
  - Else: no change. cnt saturates and never wraps.
- Pulses shorter than one scan period may be missed by design.
- Latency, raw edge to stable_out change: 2 sync cycles + 0..NUM_CH-1 wait + (STABLE_CNT+1)*NUM_CH cycles. At most one event per cycle, so no intra-cycle arbitration is needed. Simultaneous raw edges are reported in scan order.
- Queue: synchronous FIFO with registered outputs.
  - Pop when evt_valid && evt_ready.
  - Push while empty: evt_valid=1 on the next cycle.
  - evt_ch and evt_rise stay stable while evt_valid && !evt_ready.
  - Push while full with no pop: event dropped, stable_out still updates, ovf <= 1.
  - Push and pop in the same cycle while full: push accepted, occupancy unchanged.
  - Push and pop in the same cycle while empty is impossible (push data is not yet visible).
- ovf: set on a drop; cleared by clr_ovf. Set wins over clear in the same cycle.

Optional Feature:
- KEY_EVENT_CTRL_TIMESTAMP_EN defined:
  - Adds a 16-bit free-running cycle counter, reset to 0, wrapping at 65535→0.
  - Adds output evt_ts[15:0], captured at push and stored alongside each FIFO entry, same handshake.
- Not defined: no counter, no evt_ts port, FIFO width is CH_W+1.

Decomposition:
- Package key_evt_pkg:
  - evt_t struct {ch, rise[, ts]}.
  - TS_W=16.
  - clog2-based CH_W helper function.
- Sub-module evt_fifo: parameterised sync FIFO (WIDTH, DEPTH), full/empty flags, synchronous active-low reset. Reusable by other FT2232H-side producers.

Test Plan (NUM_CH=4, STABLE_CNT=3, FIFO_DEPTH=8 unless noted):
- Reset: rst_n=0 for 2 cycles with raw_in=4'hF → stable_out=0, evt_valid=0, ovf=0. Release; hold raw_in=4'hF → all four channels rise, 4 events ch0..ch3, rise=1, in scan order.
- Single press: raw_in[2] 0→1 and held, evt_ready=1 → stable_out[2] rises 18..22 cycles after the raw edge. Exactly one event {ch=2, rise=1}. Release → one event {2, 0}.
- Glitch: raw_in[1] high for 10 cycles then low → no stable_out change, no event.
- Backpressure/overflow: evt_ready=0, produce 9 edges → 8 queued, ovf=1, evt data held stable. Raise evt_ready → 8 events drained in push order. Pulse clr_ovf → ovf=0.
- Full with simultaneous pop: FIFO full, evt_ready=1 in the same cycle as a new push → no drop, ovf stays 0.
- Mid-op reset: 5 events queued, assert rst_n=0 for 1 cycle → evt_valid=0 and stable_out=0 from that edge. No stale events after release.
